// File: rtl/addsub_pkg.sv
// Shared definitions for the serial nibble adder/subtractor: state encoding,
// slice width, operation codes and the counter-width helper.
package addsub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int NIBBLE_W = 4;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Nibble counter needs at least one bit even for a single-nibble operand.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nibble_addsub.sv
// One 4-bit adder/subtractor slice: s = x + (y ^ {4{op}}) + cin, with carry out
// of bit 3 and carry into bit 3 (used for signed overflow on the top nibble).
module nibble_addsub
   import addsub_pkg::*;
(
   input  logic [NIBBLE_W-1:0] x,
   input  logic [NIBBLE_W-1:0] y,
   input  logic                op,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] s,
   output logic                cout,
   output logic                c3
);

   logic [NIBBLE_W-1:0] y_eff;
   logic [NIBBLE_W:0]   sum_full;
   logic [NIBBLE_W-1:0] sum_low;

   assign y_eff    = y ^ {NIBBLE_W{op}};
   assign sum_full = {1'b0, x} + {1'b0, y_eff} + {{NIBBLE_W{1'b0}}, cin};
   assign sum_low  = {1'b0, x[NIBBLE_W-2:0]} + {1'b0, y_eff[NIBBLE_W-2:0]}
                     + {{(NIBBLE_W-1){1'b0}}, cin};

   assign s    = sum_full[NIBBLE_W-1:0];
   assign cout = sum_full[NIBBLE_W];
   assign c3   = sum_low[NIBBLE_W-1];

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Serial W-bit add/subtract controller: one nibble per cycle, LSB first,
// through a single shared slice; carry chains through a register.
module serial_addsub_ctrl
   import addsub_pkg::*;
#(
   parameter int NIBBLES = 4
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     op,
   input  logic [NIBBLE_W*NIBBLES-1:0] a,
   input  logic [NIBBLE_W*NIBBLES-1:0] b,
   output logic                     busy,
   output logic                     done,
   output logic [NIBBLE_W*NIBBLES-1:0] result,
   output logic                     carry,
   output logic                     ovf
);

   localparam int              W    = NIBBLE_W * NIBBLES;
   localparam int              CW   = cnt_width(NIBBLES);
   localparam logic [CW-1:0]   LAST = CW'(NIBBLES - 1);

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [W-1:0]        a_q;
   logic [W-1:0]        b_q;
   logic                op_q;
   logic [NIBBLE_W-1:0] x;
   logic [NIBBLE_W-1:0] y;
   logic [NIBBLE_W-1:0] s;
   logic                cout;
   logic                c3;

   // Slice inputs come only from captured operands and the carry register.
   assign x = a_q[int'(cnt)*NIBBLE_W +: NIBBLE_W];
   assign y = b_q[int'(cnt)*NIBBLE_W +: NIBBLE_W];

   nibble_addsub u_slice (
      .x    (x),
      .y    (y),
      .op   (op_q),
      .cin  (carry),
      .s    (s),
      .cout (cout),
      .c3   (c3)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= OP_ADD;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         carry  <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_q   <= a;
                  b_q   <= b;
                  op_q  <= op;
                  carry <= op;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               result[int'(cnt)*NIBBLE_W +: NIBBLE_W] <= s;
               carry <= cout;
               if (cnt == LAST) begin
                  ovf   <= c3 ^ cout;
                  cnt   <= '0;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DONE: begin
               // done is registered, so it is seen the cycle after DONE.
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Bench for serial_addsub_ctrl: directed corner cases, random operations,
// continuous-start throughput, mid-run reset and back-to-back requests.
module tb_serial_addsub_ctrl;
   import addsub_pkg::*;

   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         op    = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry;
   logic         ovf;

   int n_checks = 0;
   int n_fail   = 0;

   // Entries are {carry, ovf, result}.
   logic [W+1:0] exp_q[$];

   always #5 clk = ~clk;

   serial_addsub_ctrl #(.NIBBLES(NIB)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .carry  (carry),
      .ovf    (ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain unsigned and signed integer arithmetic on whole operands.
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic o);
      longint ua, ub, sa, sb, ur, sr;
      logic   c, v;
      logic [W-1:0] r;
      ua = longint'(x);
      ub = longint'(y);
      sa = longint'($signed(x));
      sb = longint'($signed(y));
      if (o == OP_SUB) begin
         ur = ua - ub;
         sr = sa - sb;
         c  = (ua >= ub);
      end else begin
         ur = ua + ub;
         sr = sa + sb;
         c  = (ur >= (longint'(1) << W));
      end
      r = ur[W-1:0];
      v = (sr > ((longint'(1) << (W-1)) - 1)) || (sr < -(longint'(1) << (W-1)));
      return {c, v, r};
   endfunction

   task automatic check_result(input string tag);
      logic [W+1:0] e;
      if (exp_q.size() == 0) begin
         check($sformatf("%s_queue", tag), 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check($sformatf("%s_result", tag), 32'(result), 32'(e[W-1:0]));
         check($sformatf("%s_carry", tag), 32'(carry), 32'(e[W+1]));
         check($sformatf("%s_ovf", tag), 32'(ovf), 32'(e[W]));
      end
   endtask

   // Waits for done after an accept edge; returns edges counted (21 = timeout).
   task automatic wait_done(output int k);
      for (k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (done) break;
      end
   endtask

   task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xop,
                         input string tag);
      int k;
      @(negedge clk);
      a = xa; b = xb; op = xop; start = 1'b1;
      exp_q.push_back(model(xa, xb, xop));
      @(posedge clk);
      #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); op = 1'($urandom);
      check($sformatf("%s_busy", tag), 32'(busy), 32'd1);
      wait_done(k);
      check($sformatf("%s_latency", tag), 32'(k), 32'd5);
      if (done) begin
         check_result(tag);
         check($sformatf("%s_busy_low", tag), 32'(busy), 32'd0);
      end else if (exp_q.size() > 0) begin
         void'(exp_q.pop_front());
      end
      @(posedge clk);
      #1;
      check($sformatf("%s_pulse", tag), 32'(done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] ra, rb;
      logic         ro;
      logic         seen;
      int           k;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_carry", 32'(carry), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("idle_busy", 32'(busy), 32'd0);

      // Directed corner cases
      run_op(16'h1234, 16'h0FFF, OP_ADD, "add_basic");
      run_op(16'hFFFF, 16'h0001, OP_ADD, "add_wrap");
      run_op(16'h7FFF, 16'h0001, OP_ADD, "add_ovf");
      run_op(16'h8000, 16'h0001, OP_SUB, "sub_ovf");
      run_op(16'h0005, 16'h0008, OP_SUB, "sub_borrow");
      run_op(16'h1234, 16'h1234, OP_SUB, "sub_equal");

      // Random operations
      for (int i = 0; i < 20; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
      end

      // Start held high with operands changing every cycle
      for (int n = 0; n < 36; n++) begin
         @(negedge clk);
         ra = W'($urandom); rb = W'($urandom); ro = 1'($urandom_range(0, 1));
         a = ra; b = rb; op = ro; start = 1'b1;
         if (n % 6 == 0) exp_q.push_back(model(ra, rb, ro));
         @(posedge clk);
         #1;
         check($sformatf("cont_done%0d", n), 32'(done), 32'((n % 6) == 5));
         if (done) check_result($sformatf("cont%0d", n));
      end
      @(negedge clk);
      start = 1'b0;
      exp_q.delete();
      repeat (8) @(posedge clk);

      // Reset pulsed during the second RUN cycle
      @(negedge clk);
      a = 16'h1234; b = 16'h1111; op = OP_ADD; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_result", 32'(result), 32'd0);
      check("abort_carry", 32'(carry), 32'd0);
      check("abort_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk);
         #1;
         seen = seen | done;
      end
      check("abort_no_done", 32'(seen), 32'd0);
      run_op(16'h0003, 16'h0004, OP_ADD, "after_abort");

      // Start in the DONE cycle is ignored; start in the next IDLE cycle is taken
      @(negedge clk);
      a = 16'h0100; b = 16'h0022; op = OP_ADD; start = 1'b1;
      exp_q.push_back(model(16'h0100, 16'h0022, OP_ADD));
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      a = 16'hAAAA; b = 16'h1111; op = OP_SUB; start = 1'b1;
      @(posedge clk);
      #1;
      check("b2b_first_done", 32'(done), 32'd1);
      check("b2b_ignored_busy", 32'(busy), 32'd0);
      if (done) check_result("b2b_first");
      @(negedge clk);
      a = 16'h4000; b = 16'h4000; op = OP_ADD;
      exp_q.push_back(model(16'h4000, 16'h4000, OP_ADD));
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b_accept_busy", 32'(busy), 32'd1);
      check("b2b_accept_done", 32'(done), 32'd0);
      wait_done(k);
      check("b2b_latency", 32'(k), 32'd5);
      if (done) check_result("b2b_second");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
